// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM that sequences the multicycle MIPS datapath
// through fetch/decode/execute/memory/writeback, with a ready handshake and a
// wait-counter timeout on memory accesses.
// Optional build macro: MCU_BNE_EN -- decode opcode 000101 (BNE) as a branch
// taken on ~Zero. Without it, 000101 is treated as an illegal opcode.
module multicycle_control_unit #(
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               AluSrcA,
  output logic [1:0]         AluSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic               PCWrite,
  output logic               PCEn,
  output logic               illegal,
  output logic               bus_err,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIWB = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCU_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_req, r_iord, r_alu_src_a, r_reg_dst, r_mem_to_reg, r_reg_write;
  logic [1:0]       r_alu_src_b, r_alu_op, r_pc_src;
  // State flags for the outputs that are additionally qualified by inputs.
  logic             r_in_fetch, r_in_memwr, r_in_branch, r_in_jump;
`ifdef MCU_BNE_EN
  logic             r_is_bne;
`endif
  logic [5:0]       w_op;
  logic             w_timeout, w_illegal, w_br_taken;
  logic             w_unused;

  assign w_op     = Instr[INSTR_W-1 -: 6];
  assign w_unused = ^Instr[INSTR_W-7:0];

  // A memory wait gives up once the counter has seen TIMEOUT-1 idle cycles;
  // a ready arriving in that same cycle still completes the access.
  assign w_timeout = r_mem_req && !mem_ready && (r_cnt == CNT_LAST);

  // Next-state decode; opcode is only looked at in DECODE and MEMADR.
  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (w_op)
          OP_LW, OP_SW, OP_ADDI: w_next = S_MEMADR;
          OP_RTYPE:              w_next = S_EXEC;
          OP_BEQ:                w_next = S_BRANCH;
          OP_J:                  w_next = S_JUMP;
`ifdef MCU_BNE_EN
          OP_BNE:                w_next = S_BRANCH;
`endif
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        case (w_op)
          OP_LW:   w_next = S_MEMRD;
          OP_SW:   w_next = S_MEMWR;
          OP_ADDI: w_next = S_ADDIWB;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      default:  w_next = S_FETCH;
    endcase
    if (w_timeout) w_next = S_FETCH;
  end

  // State, wait counter and Moore outputs, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_cnt        <= '0;
      r_mem_req    <= 1'b1;
      r_iord       <= 1'b0;
      r_alu_src_a  <= 1'b0;
      r_alu_src_b  <= 2'b01;
      r_alu_op     <= 2'b00;
      r_pc_src     <= 2'b00;
      r_reg_dst    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_in_fetch   <= 1'b1;
      r_in_memwr   <= 1'b0;
      r_in_branch  <= 1'b0;
      r_in_jump    <= 1'b0;
`ifdef MCU_BNE_EN
      r_is_bne     <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || w_timeout)
        r_cnt <= '0;
      else if (r_mem_req && !mem_ready)
        r_cnt <= r_cnt + CNT_W'(1);
`ifdef MCU_BNE_EN
      // BRANCH no longer looks at Instr, so remember which flavour was decoded.
      if (r_state == S_DECODE) r_is_bne <= (w_op == OP_BNE);
`endif
      r_mem_req    <= 1'b0;
      r_iord       <= 1'b0;
      r_alu_src_a  <= 1'b0;
      r_alu_src_b  <= 2'b00;
      r_alu_op     <= 2'b00;
      r_pc_src     <= 2'b00;
      r_reg_dst    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_in_fetch   <= 1'b0;
      r_in_memwr   <= 1'b0;
      r_in_branch  <= 1'b0;
      r_in_jump    <= 1'b0;
      case (w_next)
        S_FETCH:  begin r_mem_req <= 1'b1; r_alu_src_b <= 2'b01; r_in_fetch <= 1'b1; end
        S_DECODE: r_alu_src_b <= 2'b11;
        S_MEMADR: begin r_alu_src_a <= 1'b1; r_alu_src_b <= 2'b10; end
        S_MEMRD:  begin r_mem_req <= 1'b1; r_iord <= 1'b1; end
        S_MEMWB:  begin r_mem_to_reg <= 1'b1; r_reg_write <= 1'b1; end
        S_MEMWR:  begin r_mem_req <= 1'b1; r_iord <= 1'b1; r_in_memwr <= 1'b1; end
        S_EXEC:   begin r_alu_src_a <= 1'b1; r_alu_op <= 2'b10; end
        S_ALUWB:  begin r_reg_dst <= 1'b1; r_reg_write <= 1'b1; end
        S_BRANCH: begin
          r_alu_src_a <= 1'b1;
          r_alu_op    <= 2'b01;
          r_pc_src    <= 2'b01;
          r_in_branch <= 1'b1;
        end
        S_ADDIWB: r_reg_write <= 1'b1;
        S_JUMP:   begin r_pc_src <= 2'b10; r_in_jump <= 1'b1; end
        default:  ;
      endcase
    end
  end

`ifdef MCU_BNE_EN
  assign w_br_taken = r_in_branch && (r_is_bne ? !Zero : Zero);
`else
  assign w_br_taken = r_in_branch && Zero;
`endif

  assign mem_req  = r_mem_req;
  assign IorD     = r_iord;
  assign AluSrcA  = r_alu_src_a;
  assign AluSrcB  = r_alu_src_b;
  assign ALUOp    = r_alu_op;
  assign PCSrc    = r_pc_src;
  assign RegDst   = r_reg_dst;
  assign MemtoReg = r_mem_to_reg;
  assign RegWrite = r_reg_write;
  assign IRWrite  = r_in_fetch && mem_ready;
  assign PCWrite  = (r_in_fetch && mem_ready) || r_in_jump;
  assign MemWrite = r_in_memwr && mem_ready;
  assign PCEn     = PCWrite || w_br_taken;
  assign illegal  = w_illegal;
  assign bus_err  = w_timeout && rst_n;
  assign state    = r_state;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-FSM control unit for the multicycle MIPS datapath; replaces the single-cycle combinational ControlUnit.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives per-state datapath enables and handles a ready-handshake to variable-latency memory with a timeout.
- Sits between the instruction register / memory interface and the shared ALU/register file datapath.

Parameters:
- INSTR_W, 32, instruction width; the opcode is Instr[INSTR_W-1:INSTR_W-6].
- TIMEOUT, 16, maximum cycles to wait for mem_ready before abort; legal range 1..255.
- CNT_W, 8, width of the wait counter; must hold TIMEOUT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Instr  input  INSTR_W  instruction register contents; valid from DECODE onward
- Zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- mem_req  output  1  memory access request
- IorD  output  1  address mux: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write
- IRWrite  output  1  load instruction register
- RegDst  output  1  write register: 1 = rd, 0 = rt
- MemtoReg  output  1  write data: 1 = MDR, 0 = ALUOut
- RegWrite  output  1  register file write
- AluSrcA  output  1  0 = PC, 1 = A register
- AluSrcB  output  2  00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- PCWrite  output  1  unconditional PC load
- PCEn  output  1  PCWrite OR (branch condition met)
- illegal  output  1  one-cycle pulse on an unknown opcode
- bus_err  output  1  one-cycle pulse on a memory timeout
- state  output  4  current state encoding, for debug

Behaviour:
- Reset:
  - rst_n low forces state = FETCH (0) immediately, clears the wait counter, and clears illegal and bus_err.
  - All outputs are Moore-decoded from state, so during reset only FETCH outputs are active: mem_req=1, IorD=0, AluSrcA=0, AluSrcB=01, ALUOp=00, PCSrc=00. IRWrite=0 and PCWrite=0 until mem_ready. Every other output is 0.
- Opcodes:
  - R-type: 000000
  - LW: 100011
  - SW: 101011
  - BEQ: 000100
  - ADDI: 001000
  - J: 000010
- States, with encodings and transitions:
  - FETCH (0): mem_req=1. On mem_ready, pulse IRWrite=1 and PCWrite=1 (PC+4) in the same cycle, then go to DECODE. Otherwise hold.
  - DECODE (1): AluSrcA=0, AluSrcB=11, ALUOp=00 (branch target into ALUOut). Branch by opcode: LW/SW/ADDI -> MEMADR; R-type -> EXEC; BEQ -> BRANCH; J -> JUMP; any other -> FETCH with illegal=1 for this cycle.
  - MEMADR (2): AluSrcA=1, AluSrcB=10, ALUOp=00. LW -> MEMRD; SW -> MEMWR; ADDI -> ADDIWB.
  - MEMRD (3): mem_req=1, IorD=1. On mem_ready -> MEMWB.
  - MEMWB (4): RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWR (5): mem_req=1, IorD=1. MemWrite=1 only in the mem_ready cycle. On mem_ready -> FETCH.
  - EXEC (6): AluSrcA=1, AluSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB (7): RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
  - BRANCH (8): AluSrcA=1, AluSrcB=00, ALUOp=01, PCSrc=01. PCEn=Zero -> FETCH.
  - ADDIWB (9): RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
  - JUMP (10): PCSrc=10, PCWrite=1 -> FETCH.
  - Unused encodings 11–15 -> FETCH.
- Gating: IRWrite, PCWrite in FETCH, and MemWrite are qualified by mem_ready. All other outputs are pure functions of state.
- Latency with mem_ready tied high:
  - R-type: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - ADDI: 4 cycles
  - BEQ: 3 cycles
  - J: 3 cycles
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - When the counter reaches TIMEOUT-1 with mem_ready still low, the next state is FETCH, bus_err pulses for 1 cycle, and no writes occur.
  - mem_ready arriving in that same cycle wins: the access completes normally and there is no bus_err.
- Instr is sampled only in DECODE and MEMADR; changes in other states have no effect.
- Reset asserted mid-instruction aborts it with no further RegWrite or MemWrite.

Optional Feature:
- MCU_BNE_EN defined: opcode 000101 (BNE) decodes to BRANCH; in BRANCH, PCEn = ~Zero for BNE and Zero for BEQ. The opcode is latched as needed.
- Undefined: 000101 is illegal (illegal pulse, return to FETCH).

Test Plan:
- Reset then ADD:
  - Stimulus: rst_n low 2 cycles, release; mem_ready=1; Instr=32'h01095020 (add).
  - Required: state sequence 0,1,6,7,0; RegWrite=1 with RegDst=1 only in state 7; IRWrite=1 only in cycle 1.
- LW with wait states:
  - Stimulus: Instr=32'h8D090004; mem_ready low 3 cycles in MEMRD.
  - Required: state holds at 3 for 4 cycles; MEMWB asserts MemtoReg=1, RegWrite=1; bus_err=0.
- BEQ both outcomes:
  - Stimulus: Instr=32'h11090003.
  - Required: with Zero=1, PCEn=1 in state 8; with Zero=0, PCEn=0; both complete in 3 cycles.
- Timeout:
  - Stimulus: TIMEOUT=4; SW (32'hAD090008) with mem_ready held 0.
  - Required: bus_err pulses once after 4 cycles in state 5; MemWrite never asserts; next state is 0.
- Illegal opcode:
  - Stimulus: Instr=32'hFC000000.
  - Required: illegal=1 for exactly 1 cycle in DECODE; returns to FETCH; no RegWrite, MemWrite or PCWrite beyond the fetch.
- Mid-instruction reset and BNE:
  - Stimulus: assert rst_n in state 3 of an LW; separately, opcode 000101 with Zero=0.
  - Required: the reset goes to state 0 asynchronously with no RegWrite. With MCU_BNE_EN the BNE gives PCEn=1; without it, illegal=1.
